simon_host_if: RTL

Word-serial host interface placed directly upstream and downstream of the SIMON control block. It accepts key and data words over a valid/ready stream and assembles them into the core's parallel KEY and inDATA buses. It drives the core's newKEY/newDATA/enc_dec inputs and waits for the core's load acknowledges. It then captures outDATA when doneDATA rises, acknowledges it with readDATA, and returns the result as a valid/ready word stream.

---
 rtl/simon_host_if.sv | 120 ++++++++++++
 1 files changed

// File: rtl/simon_host_if.sv
// simon_host_if: word-serial valid/ready front end that assembles key/data words
// for the SIMON core and streams its two-word result back to the host.
module simon_host_if #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic             in_mode,
    input  logic [N-1:0]     in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_word,
    output logic             newKEY,
    output logic             newDATA,
    output logic             enc_dec,
    output logic [M*N-1:0]   KEY,
    output logic [2*N-1:0]   inDATA,
    input  logic             loadKEY,
    input  logic             loadDATA,
    input  logic             doneDATA,
    input  logic [2*N-1:0]   outDATA,
    output logic             readDATA
);
    localparam int KW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {COLLECT, KWAIT, DWAIT, BUSY} in_state_t;
    typedef enum logic [1:0] {EMPTY, SEND_HI, SEND_LO} out_state_t;

    in_state_t      st;
    out_state_t     ost;
    logic [KW-1:0]  kcnt;
    logic           dcnt;
    logic           key_loaded;
    logic [2*N-1:0] result;
    logic           accept;
    logic           capture;

    // Key and data frames may not interleave; data also needs a loaded key.
    assign in_ready = (st == COLLECT) &&
                      (in_sel ? !dcnt : (key_loaded && kcnt == '0));
    assign accept   = in_valid && in_ready;
    assign capture  = (ost == EMPTY) && doneDATA && !readDATA;

    assign out_valid = (ost != EMPTY);
    assign out_word  = (ost == SEND_HI) ? result[2*N-1:N] :
                       (ost == SEND_LO) ? result[N-1:0] : '0;

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            st         <= COLLECT;
            kcnt       <= '0;
            dcnt       <= 1'b0;
            key_loaded <= 1'b0;
            newKEY     <= 1'b0;
            newDATA    <= 1'b0;
            enc_dec    <= 1'b0;
            KEY        <= '0;
            inDATA     <= '0;
        end else begin
            case (st)
                COLLECT: if (accept) begin
                    if (in_sel) begin
                        KEY[(M-1-int'(kcnt))*N +: N] <= in_word;
                        if (kcnt == KW'(M-1)) begin
                            kcnt   <= '0;
                            newKEY <= 1'b1;
                            st     <= KWAIT;
                        end else begin
                            kcnt <= kcnt + 1'b1;
                        end
                    end else if (!dcnt) begin
                        inDATA[2*N-1:N] <= in_word;
                        enc_dec         <= in_mode;
                        dcnt            <= 1'b1;
                    end else begin
                        inDATA[N-1:0] <= in_word;
                        dcnt          <= 1'b0;
                        newDATA       <= 1'b1;
                        st            <= DWAIT;
                    end
                end
                KWAIT: if (loadKEY) begin
                    newKEY     <= 1'b0;
                    key_loaded <= 1'b1;
                    st         <= COLLECT;
                end
                DWAIT: if (loadDATA) begin
                    newDATA <= 1'b0;
                    st      <= BUSY;
                end
                BUSY: if (capture) st <= COLLECT;
                default: st <= COLLECT;
            endcase
        end
    end

    // Results stay pending in the core while a previous result is streaming.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            ost      <= EMPTY;
            result   <= '0;
            readDATA <= 1'b0;
        end else begin
            readDATA <= capture;
            case (ost)
                EMPTY: if (capture) begin
                    result <= outDATA;
                    ost    <= SEND_HI;
                end
                SEND_HI: if (out_ready) ost <= SEND_LO;
                SEND_LO: if (out_ready) ost <= EMPTY;
                default: ost <= EMPTY;
            endcase
        end
    end
endmodule
